nmcu_tile_scheduler: RTL and testbench
======================================

Name: nmcu_tile_scheduler

Overview:
- Upstream controller for one nmcu instance: splits a full feature map into per-output-pixel "cones" and runs the nmcu once per cone.
- For each output pixel it computes the cone's input start address and output address, drives the nmcu configuration ports, pulses start, and waits for done.
- Configured and launched by the host or top-level sequencer; reports completion, tile count and watchdog errors.

Parameters:
- ADDR_WIDTH, 16, address width; matches nmcu.
- MAX_INPUT_DIM, 15, largest full map dimension; dimension ports are DW = $clog2(MAX_INPUT_DIM)+1 bits wide.
- TIMEOUT_CYCLES, 65535, maximum cycles allowed in WAIT_DONE before aborting.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  launch request; sampled only in IDLE
- desc_addr  in  ADDR_WIDTH  descriptor base, passed to nmcu unchanged
- in_base  in  ADDR_WIDTH  address of input pixel (0,0)
- out_base  in  ADDR_WIDTH  address of output pixel (0,0)
- full_in_w, full_in_h  in  DW  full input map dimensions
- full_out_w, full_out_h  in  DW  full output map dimensions
- cone_stride  in  4  input-pixel step between horizontally/vertically adjacent cones
- busy  out  1  high from accept until finish
- done  out  1  one-cycle pulse at finish
- err  out  1  sticky watchdog error; cleared by the next accepted start
- tiles_done  out  8  cones completed in the current or last run
- nmcu_start  out  1  one-cycle start pulse to nmcu
- nmcu_done  in  1  nmcu completion (level)
- nmcu_desc, nmcu_input_addr, nmcu_output_addr  out  ADDR_WIDTH  nmcu configuration
- nmcu_full_input_width/height, nmcu_full_output_width/height  out  DW  latched copies of the full dimensions

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk. Every output resets to 0 and the FSM enters IDLE. If rst asserts mid-run, the run is abandoned and nmcu_start is low on the following edge.
- Configuration latch: all configuration inputs are latched on the cycle start is accepted. Later input changes have no effect until the next run.
- States: IDLE, ISSUE, WAIT_DONE, ADVANCE, FINISH.
- IDLE:
  - On start, latch configuration; clear err and tiles_done; oy=ox=0.
  - Initialise row_in_addr=in_base, col_in_addr=in_base, row_out_addr=out_base, col_out_addr=out_base.
  - If full_out_w==0 or full_out_h==0, go to FINISH. Otherwise go to ISSUE.
- ISSUE (1 cycle):
  - nmcu_input_addr<=col_in_addr; nmcu_output_addr<=col_out_addr; nmcu_start<=1; reset the watchdog counter; go to WAIT_DONE.
  - nmcu_start is high for exactly one cycle per cone. The address registers are valid in the same cycle as nmcu_start and stay stable until the next ISSUE.
- WAIT_DONE:
  - The first cycle after ISSUE ignores nmcu_done, which covers nmcu's one-cycle done-clear latency.
  - After that, nmcu_done==1 increments tiles_done and goes to ADVANCE.
  - If the counter reaches TIMEOUT_CYCLES first: err<=1, go to FINISH.
- ADVANCE (1 cycle): address generation is incremental, with no multipliers.
  - If ox<full_out_w-1: ox++, col_in_addr+=cone_stride, col_out_addr+=1.
  - Else if oy<full_out_h-1: oy++, ox=0, row_in_addr+=cone_stride*full_in_w, row_out_addr+=full_out_w. Both col_* registers load the new row_* values.
  - Else go to FINISH. On all other branches go to ISSUE.
  - Address arithmetic is modulo 2^ADDR_WIDTH; wrap is not detected.
- FINISH: done<=1 for one cycle, busy<=0, return to IDLE.
- Latencies:
  - busy rises the cycle after start is accepted.
  - Per-cone overhead is 3 cycles beyond nmcu latency.
- Boundary and ignore rules:
  - start while busy is ignored.
  - nmcu_done outside WAIT_DONE is ignored.
  - tiles_done saturates at 255.
  - cone_stride==0 is legal: every cone gets the same input address.

Decomposition:
- Package nmcu_pkg:
  - state enum sched_state_t
  - layer_type_t, shared with nmcu
  - localparam DIM_W
- Sub-module nmcu_addr_gen: holds oy/ox and the row/col accumulators. Inputs are init and step; outputs are the two addresses and a last flag. The FSM stays in the top module.

Test Plan:
- 2x2 output, full_in_w=5, stride=2, in_base=0x100, out_base=0x200, nmcu_done after 4 cycles → input addrs 0x100, 0x102, 0x10A, 0x10C; output addrs 0x200, 0x201, 0x202, 0x203; 4 nmcu_start pulses; done pulse; tiles_done=4.
- full_out_w=0 → no nmcu_start; done pulses 2 cycles after start; tiles_done=0.
- nmcu_done never asserts, TIMEOUT_CYCLES=16 → err=1 and done pulse after 16 WAIT_DONE cycles; next start clears err.
- start re-asserted during run and nmcu_done glitched high in ADVANCE → no extra cones issued; tile count correct.
- rst asserted during WAIT_DONE of the 2nd cone → all outputs 0 asynchronously; a fresh start restarts from in_base.
- 1x1 output → exactly one cone with nmcu_input_addr=in_base; nmcu_desc and the full_* outputs equal the latched inputs.

Source files
------------

// File: rtl/nmcu_pkg.sv
// Shared types and constants for the nmcu tile scheduler and the nmcu datapath.
package nmcu_pkg;

  localparam int DIM_W = $clog2(15) + 1;

  typedef enum logic [2:0] {
    SCHED_IDLE      = 3'd0,
    SCHED_ISSUE     = 3'd1,
    SCHED_WAIT_DONE = 3'd2,
    SCHED_ADVANCE   = 3'd3,
    SCHED_FINISH    = 3'd4
  } sched_state_t;

  typedef enum logic [1:0] {
    LAYER_CONV   = 2'd0,
    LAYER_DWCONV = 2'd1,
    LAYER_POOL   = 2'd2,
    LAYER_FC     = 2'd3
  } layer_type_t;

endpackage

// File: rtl/nmcu_addr_gen.sv
// Incremental cone address generator: walks output pixels row-major and keeps
// row/column accumulators for the cone input and output addresses.
module nmcu_addr_gen
  import nmcu_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DW         = DIM_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] in_base,
  input  logic [ADDR_WIDTH-1:0] out_base,
  input  logic [3:0]            stride,
  input  logic [DW-1:0]         in_w,
  input  logic [DW-1:0]         out_w,
  input  logic [DW-1:0]         out_h,
  output logic [ADDR_WIDTH-1:0] in_addr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  last
);

  logic [DW-1:0]         ox;
  logic [DW-1:0]         oy;
  logic [ADDR_WIDTH-1:0] row_in;
  logic [ADDR_WIDTH-1:0] col_in;
  logic [ADDR_WIDTH-1:0] row_out;
  logic [ADDR_WIDTH-1:0] col_out;
  logic [ADDR_WIDTH-1:0] row_step;
  logic [ADDR_WIDTH-1:0] next_row_in;
  logic [ADDR_WIDTH-1:0] next_row_out;

  // stride*in_w built as a 4-term shift-and-add; only valid once config is latched
  always_comb begin
    row_step = '0;
    for (int i = 0; i < 4; i++) begin
      if (stride[i]) begin
        row_step = row_step + (ADDR_WIDTH'(in_w) << i);
      end
    end
  end

  assign next_row_in  = row_in + row_step;
  assign next_row_out = row_out + ADDR_WIDTH'(out_w);
  assign in_addr      = col_in;
  assign out_addr     = col_out;
  assign last         = (ox == out_w - DW'(1)) && (oy == out_h - DW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ox      <= '0;
      oy      <= '0;
      row_in  <= '0;
      col_in  <= '0;
      row_out <= '0;
      col_out <= '0;
    end else if (init) begin
      ox      <= '0;
      oy      <= '0;
      row_in  <= in_base;
      col_in  <= in_base;
      row_out <= out_base;
      col_out <= out_base;
    end else if (step) begin
      if (ox < out_w - DW'(1)) begin
        ox      <= ox + DW'(1);
        col_in  <= col_in + ADDR_WIDTH'(stride);
        col_out <= col_out + ADDR_WIDTH'(1);
      end else if (oy < out_h - DW'(1)) begin
        ox      <= '0;
        oy      <= oy + DW'(1);
        row_in  <= next_row_in;
        col_in  <= next_row_in;
        row_out <= next_row_out;
        col_out <= next_row_out;
      end
    end
  end

endmodule

// File: rtl/nmcu_tile_scheduler.sv
// Runs one nmcu once per output-pixel cone of a full feature map, issuing
// per-cone addresses and guarding each cone with a watchdog.
module nmcu_tile_scheduler
  import nmcu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int MAX_INPUT_DIM  = 15,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int DW            = $clog2(MAX_INPUT_DIM) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] desc_addr,
  input  logic [ADDR_WIDTH-1:0] in_base,
  input  logic [ADDR_WIDTH-1:0] out_base,
  input  logic [DW-1:0]         full_in_w,
  input  logic [DW-1:0]         full_in_h,
  input  logic [DW-1:0]         full_out_w,
  input  logic [DW-1:0]         full_out_h,
  input  logic [3:0]            cone_stride,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            tiles_done,
  output logic                  nmcu_start,
  input  logic                  nmcu_done,
  output logic [ADDR_WIDTH-1:0] nmcu_desc,
  output logic [ADDR_WIDTH-1:0] nmcu_input_addr,
  output logic [ADDR_WIDTH-1:0] nmcu_output_addr,
  output logic [DW-1:0]         nmcu_full_input_width,
  output logic [DW-1:0]         nmcu_full_input_height,
  output logic [DW-1:0]         nmcu_full_output_width,
  output logic [DW-1:0]         nmcu_full_output_height
);

  localparam logic [2:0] IDLE      = SCHED_IDLE;
  localparam logic [2:0] ISSUE     = SCHED_ISSUE;
  localparam logic [2:0] WAIT_DONE = SCHED_WAIT_DONE;
  localparam logic [2:0] ADVANCE   = SCHED_ADVANCE;
  localparam logic [2:0] FINISH    = SCHED_FINISH;

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]            state;
  logic [WD_W-1:0]       wd_count;
  logic [3:0]            stride_q;
  logic                  gen_init;
  logic                  gen_step;
  logic                  gen_last;
  logic [ADDR_WIDTH-1:0] gen_in_addr;
  logic [ADDR_WIDTH-1:0] gen_out_addr;

  assign gen_init = (state == IDLE) && start;
  assign gen_step = (state == ADVANCE) && !gen_last;

  nmcu_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DW         (DW)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .init     (gen_init),
    .step     (gen_step),
    .in_base  (in_base),
    .out_base (out_base),
    .stride   (stride_q),
    .in_w     (nmcu_full_input_width),
    .out_w    (nmcu_full_output_width),
    .out_h    (nmcu_full_output_height),
    .in_addr  (gen_in_addr),
    .out_addr (gen_out_addr),
    .last     (gen_last)
  );

  // Watchdog counts 0..TIMEOUT_CYCLES-1; the first WAIT_DONE cycle (count 0)
  // ignores nmcu_done because the nmcu needs a cycle to drop its old done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                   <= IDLE;
      wd_count                <= '0;
      stride_q                <= '0;
      busy                    <= 1'b0;
      done                    <= 1'b0;
      err                     <= 1'b0;
      tiles_done              <= '0;
      nmcu_start              <= 1'b0;
      nmcu_desc               <= '0;
      nmcu_input_addr         <= '0;
      nmcu_output_addr        <= '0;
      nmcu_full_input_width   <= '0;
      nmcu_full_input_height  <= '0;
      nmcu_full_output_width  <= '0;
      nmcu_full_output_height <= '0;
    end else begin
      nmcu_start <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            nmcu_desc               <= desc_addr;
            nmcu_full_input_width   <= full_in_w;
            nmcu_full_input_height  <= full_in_h;
            nmcu_full_output_width  <= full_out_w;
            nmcu_full_output_height <= full_out_h;
            stride_q                <= cone_stride;
            err                     <= 1'b0;
            tiles_done              <= '0;
            busy                    <= 1'b1;
            state <= ((full_out_w == '0) || (full_out_h == '0)) ? FINISH : ISSUE;
          end
        end
        ISSUE: begin
          nmcu_input_addr  <= gen_in_addr;
          nmcu_output_addr <= gen_out_addr;
          nmcu_start       <= 1'b1;
          wd_count         <= '0;
          state            <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if ((wd_count != '0) && nmcu_done) begin
            if (tiles_done != 8'hFF) begin
              tiles_done <= tiles_done + 8'd1;
            end
            state <= ADVANCE;
          end else if (wd_count == WD_LAST) begin
            err   <= 1'b1;
            state <= FINISH;
          end else begin
            wd_count <= wd_count + WD_W'(1);
          end
        end
        ADVANCE: begin
          state <= gen_last ? FINISH : ISSUE;
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nmcu_tile_scheduler.sv
// Randomized self-checking bench: a behavioural nmcu drives nmcu_done and each
// run's cone addresses are compared against a nested-loop reference model.
module tb_nmcu_tile_scheduler;

  localparam int AW = 16;
  localparam int DW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] desc_addr = '0;
  logic [AW-1:0] in_base = '0;
  logic [AW-1:0] out_base = '0;
  logic [DW-1:0] full_in_w = '0;
  logic [DW-1:0] full_in_h = '0;
  logic [DW-1:0] full_out_w = '0;
  logic [DW-1:0] full_out_h = '0;
  logic [3:0]    cone_stride = '0;
  logic          busy;
  logic          done;
  logic          err;
  logic [7:0]    tiles_done;
  logic          nmcu_start;
  logic          nmcu_done = 1'b0;
  logic [AW-1:0] nmcu_desc;
  logic [AW-1:0] nmcu_input_addr;
  logic [AW-1:0] nmcu_output_addr;
  logic [DW-1:0] nmcu_full_input_width;
  logic [DW-1:0] nmcu_full_input_height;
  logic [DW-1:0] nmcu_full_output_width;
  logic [DW-1:0] nmcu_full_output_height;

  int checks = 0;
  int errors = 0;
  int nmcu_lat = 4;
  bit nmcu_hang = 1'b0;

  nmcu_tile_scheduler #(
    .ADDR_WIDTH     (AW),
    .MAX_INPUT_DIM  (15),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .start                   (start),
    .desc_addr               (desc_addr),
    .in_base                 (in_base),
    .out_base                (out_base),
    .full_in_w               (full_in_w),
    .full_in_h               (full_in_h),
    .full_out_w              (full_out_w),
    .full_out_h              (full_out_h),
    .cone_stride             (cone_stride),
    .busy                    (busy),
    .done                    (done),
    .err                     (err),
    .tiles_done              (tiles_done),
    .nmcu_start              (nmcu_start),
    .nmcu_done               (nmcu_done),
    .nmcu_desc               (nmcu_desc),
    .nmcu_input_addr         (nmcu_input_addr),
    .nmcu_output_addr        (nmcu_output_addr),
    .nmcu_full_input_width   (nmcu_full_input_width),
    .nmcu_full_input_height  (nmcu_full_input_height),
    .nmcu_full_output_width  (nmcu_full_output_width),
    .nmcu_full_output_height (nmcu_full_output_height)
  );

  always #5 clk = ~clk;

  // Behavioural nmcu: old done lingers one cycle after start, then drops,
  // then rises nmcu_lat cycles later and holds until the next start.
  int nm_phase = 0;
  int nm_rem   = 0;
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      nmcu_done = 1'b0;
      nm_phase  = 0;
    end else if (nmcu_start) begin
      nm_phase = 1;
    end else if (nm_phase == 1) begin
      nmcu_done = 1'b0;
      nm_rem    = nmcu_lat;
      nm_phase  = 2;
    end else if (nm_phase == 2) begin
      if (nm_rem > 1) begin
        nm_rem--;
      end else begin
        if (!nmcu_hang) nmcu_done = 1'b1;
        nm_phase = 0;
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_status"}, {28'd0, busy, done, err, nmcu_start}, 32'd0);
    check_output({tag, "_tiles"}, {24'd0, tiles_done}, 32'd0);
    check_output({tag, "_addrs"}, {nmcu_input_addr, nmcu_output_addr}, 32'd0);
    check_output({tag, "_cfg"}, {nmcu_desc, 6'd0, nmcu_full_input_width, nmcu_full_output_height}, 32'd0);
  endtask

  task automatic apply_stimulus(input string tag, input logic [15:0] desc, inb, outb,
                                input int inw, inh, ow, oh, stride, lat,
                                input bit hang, noise, input int abort_at, input int exp_done_cyc);
    logic [15:0] exp_in[$];
    logic [15:0] exp_out[$];
    logic [15:0] cap_in[$];
    logic [15:0] cap_out[$];
    int k = 1;
    int dbl = 0;
    bit prev_start = 1'b0;
    bit got_done = 1'b0;
    int n_exp;

    for (int y = 0; y < oh; y++) begin
      for (int x = 0; x < ow; x++) begin
        exp_in.push_back(16'(int'(inb) + y * stride * inw + x * stride));
        exp_out.push_back(16'(int'(outb) + y * ow + x));
      end
    end
    n_exp = exp_in.size();

    @(negedge clk);
    desc_addr   = desc;
    in_base     = inb;
    out_base    = outb;
    full_in_w   = DW'(inw);
    full_in_h   = DW'(inh);
    full_out_w  = DW'(ow);
    full_out_h  = DW'(oh);
    cone_stride = 4'(stride);
    nmcu_lat    = lat;
    nmcu_hang   = hang;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    check_output({tag, "_err_clear"}, {31'd0, err}, 32'd0);

    while (!got_done && k < 3000) begin
      if (nmcu_start) begin
        cap_in.push_back(nmcu_input_addr);
        cap_out.push_back(nmcu_output_addr);
        if (prev_start) dbl++;
      end
      prev_start = nmcu_start;
      if (done) begin
        got_done = 1'b1;
      end else if (abort_at > 0 && cap_in.size() == abort_at && nmcu_start) begin
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_idle_outputs({tag, "_async_rst"});
        @(negedge clk);
        rst = 1'b0;
        return;
      end else begin
        if (noise && cap_in.size() < n_exp) begin
          start       = 1'($urandom_range(0, 1));
          in_base     = 16'($urandom);
          out_base    = 16'($urandom);
          desc_addr   = 16'($urandom);
          full_out_w  = DW'($urandom_range(0, 15));
          full_in_w   = DW'($urandom_range(0, 15));
          cone_stride = 4'($urandom);
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;

    check_output({tag, "_done_seen"}, {31'd0, got_done}, 32'd1);
    if (exp_done_cyc > 0) check_output({tag, "_done_cycle"}, k, exp_done_cyc);
    check_output({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
    check_output({tag, "_err"}, {31'd0, err}, {31'd0, hang});
    check_output({tag, "_tiles"}, {24'd0, tiles_done}, hang ? 32'd0 : n_exp);
    check_output({tag, "_cones"}, cap_in.size(), n_exp);
    check_output({tag, "_single_pulse"}, dbl, 0);
    for (int i = 0; i < n_exp && i < cap_in.size(); i++) begin
      check_output($sformatf("%s_in%0d", tag, i), {16'd0, cap_in[i]}, {16'd0, exp_in[i]});
      check_output($sformatf("%s_out%0d", tag, i), {16'd0, cap_out[i]}, {16'd0, exp_out[i]});
    end
    check_output({tag, "_desc"}, {16'd0, nmcu_desc}, {16'd0, desc});
    check_output({tag, "_full_dims"},
                 {12'd0, nmcu_full_input_width, nmcu_full_input_height,
                  nmcu_full_output_width, nmcu_full_output_height},
                 {12'd0, DW'(inw), DW'(inh), DW'(ow), DW'(oh)});
    @(negedge clk);
    check_output({tag, "_done_fall"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    apply_stimulus("basic2x2", 16'hABCD, 16'h0100, 16'h0200, 5, 5, 2, 2, 2, 4, 1'b0, 1'b0, 0, 0);
    apply_stimulus("zero_w", 16'h1111, 16'h0040, 16'h0080, 3, 3, 0, 3, 1, 2, 1'b0, 1'b0, 0, 2);
    apply_stimulus("timeout", 16'h2222, 16'h0300, 16'h0400, 2, 2, 1, 1, 1, 3, 1'b1, 1'b0, 0, 19);
    apply_stimulus("one_cone", 16'h3333, 16'h0500, 16'h0600, 7, 6, 1, 1, 3, 2, 1'b0, 1'b0, 0, 0);
    apply_stimulus("noise", 16'h4444, 16'h0700, 16'h0800, 6, 4, 3, 2, 1, 3, 1'b0, 1'b1, 0, 0);
    apply_stimulus("stride0", 16'h5555, 16'h0900, 16'hFFFE, 4, 4, 2, 2, 0, 1, 1'b0, 1'b0, 0, 0);
    apply_stimulus("abort", 16'h6666, 16'h0100, 16'h0200, 5, 5, 2, 2, 2, 4, 1'b0, 1'b0, 2, 0);
    apply_stimulus("restart", 16'h7777, 16'h0100, 16'h0200, 5, 5, 2, 2, 2, 4, 1'b0, 1'b0, 0, 0);

    for (int r = 0; r < 8; r++) begin
      apply_stimulus($sformatf("rand%0d", r), 16'($urandom), 16'($urandom), 16'($urandom),
                     $urandom_range(1, 15), $urandom_range(1, 15),
                     $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(0, 15),
                     $urandom_range(1, 6), 1'b0, 1'($urandom_range(0, 1)), 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
